// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU
// load/store port and the HOST loader/readback port.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  localparam int unsigned LOCK_MAX_DEFAULT = 8;

  // Tag of the read issued last cycle, so the return data is steered to its issuer.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam owner_t  LAST_OWNER_RST = OWN_CPU;
  localparam rd_tag_t RD_TAG_RST     = '{valid: 1'b0, owner: OWN_CPU};

  // Width of a counter that must hold values 0..max.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/command, grant and
// tagged read return.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection: round-robin between CPU and HOST, except that
// a locking HOST may keep ownership for up to LOCK_MAX consecutive grants.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT,
  parameter int unsigned CW       = cnt_width(LOCK_MAX)
) (
  input  logic          cpu_req,
  input  logic          host_req,
  input  logic          host_lock,
  input  owner_t        last_owner,
  input  logic [CW-1:0] lock_cnt,
  output logic          cpu_gnt,
  output logic          host_gnt
);

  localparam logic [CW-1:0] LockMax = CW'(LOCK_MAX);

  logic host_hold;

  always_comb begin
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    host_hold = host_lock && (last_owner == OWN_HOST) && (lock_cnt < LockMax);
    unique case ({cpu_req, host_req})
      2'b10: cpu_gnt  = 1'b1;
      2'b01: host_gnt = 1'b1;
      2'b11: begin
        if (host_hold || (last_owner == OWN_CPU)) begin
          host_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous data memory between the CPU and HOST
// ports: one access per cycle, reads tagged so data returns to the issuer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  cpu,
  dmem_arbiter_if.slave  host,
  input  logic           host_lock,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
);

  localparam int unsigned   CW      = cnt_width(LOCK_MAX);
  localparam logic [CW-1:0] LockMax = CW'(LOCK_MAX);

  logic          pick_cpu;
  logic          pick_host;
  logic          cpu_gnt;
  logic          host_gnt;
  owner_t        last_owner_q, last_owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  rd_tag_t       rd_tag_q, rd_tag_d;

  dmem_arb_pick #(
    .LOCK_MAX (LOCK_MAX),
    .CW       (CW)
  ) u_pick (
    .cpu_req    (cpu.req),
    .host_req   (host.req),
    .host_lock  (host_lock),
    .last_owner (last_owner_q),
    .lock_cnt   (lock_cnt_q),
    .cpu_gnt    (pick_cpu),
    .host_gnt   (pick_host)
  );

  // Grants are combinational, so they must also be forced low while reset is held.
  assign cpu_gnt  = pick_cpu & reset;
  assign host_gnt = pick_host & reset;

  assign cpu.gnt  = cpu_gnt;
  assign host.gnt = host_gnt;

  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_we    = host.we;
      mem_addr  = host.addr;
      mem_wdata = host.wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu.we;
      mem_addr  = cpu.addr;
      mem_wdata = cpu.wdata;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (host_gnt) begin
      last_owner_d = OWN_HOST;
    end else if (cpu_gnt) begin
      last_owner_d = OWN_CPU;
    end

    // Only HOST grants that actually keep a waiting CPU out advance the lock count.
    lock_cnt_d = lock_cnt_q;
    if (cpu_gnt || !host_lock || !cpu.req) begin
      lock_cnt_d = '0;
    end else if (host_gnt && (lock_cnt_q < LockMax)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end

    rd_tag_d.valid = mem_en & ~mem_we;
    rd_tag_d.owner = host_gnt ? OWN_HOST : OWN_CPU;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= LAST_OWNER_RST;
      lock_cnt_q   <= '0;
      rd_tag_q     <= RD_TAG_RST;
    end else begin
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  assign cpu.rvalid  = rd_tag_q.valid && (rd_tag_q.owner == OWN_CPU);
  assign host.rvalid = rd_tag_q.valid && (rd_tag_q.owner == OWN_HOST);
  assign cpu.rdata   = mem_rdata;
  assign host.rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model;
// LOCK_MAX is set to 4 so lock windows are short.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          host_lock;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem [256];

  int checks;
  int failures;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) host_if ();

  dmem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .LOCK_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .host      (host_if),
    .host_lock (host_lock),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic idle_inputs();
    cpu_if.req    = 1'b0;
    cpu_if.we     = 1'b0;
    cpu_if.addr   = '0;
    cpu_if.wdata  = '0;
    host_if.req   = 1'b0;
    host_if.we    = 1'b0;
    host_if.addr  = '0;
    host_if.wdata = '0;
    host_lock     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Reset held low with both ports requesting: every output must be zero.
  task automatic test_reset();
    reset         = 1'b0;
    host_if.req   = 1'b1;
    host_if.we    = 1'b1;
    host_if.addr  = 8'd3;
    host_if.wdata = 32'h7;
    cpu_if.req    = 1'b1;
    cpu_if.addr   = 8'd5;
    #2;
    checks++;
    if (cpu_if.gnt !== 1'b0 || host_if.gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt: got cpu=%b host=%b expected 0 0", cpu_if.gnt, host_if.gnt);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_ctl: got en=%b we=%b expected 0 0", mem_en, mem_we);
    end
    checks++;
    if (mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_mem_bus: got addr=%0h wdata=%0h expected 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (cpu_if.rvalid !== 1'b0 || host_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rvalid: got cpu=%b host=%b expected 0 0",
               cpu_if.rvalid, host_if.rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_if.req  = 1'b1;
    cpu_if.we   = 1'b0;
    cpu_if.addr = 8'd5;
    @(negedge clk);
    checks++;
    if (cpu_if.gnt !== 1'b1 || host_if.gnt !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_gnt: got cpu=%b host=%b expected 1 0", cpu_if.gnt, host_if.gnt);
    end
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd5) begin
      failures++;
      $display("FAIL cpu_read_mem: got en=%b we=%b addr=%0h expected 1 0 5",
               mem_en, mem_we, mem_addr);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (cpu_if.rvalid !== 1'b1 || host_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_rvalid: got cpu=%b host=%b expected 1 0",
               cpu_if.rvalid, host_if.rvalid);
    end
    checks++;
    if (cpu_if.rdata !== 32'h2A) begin
      failures++;
      $display("FAIL cpu_read_data: got %0h expected 2a", cpu_if.rdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    bit exp_h [4];
    logic [DW-1:0] exp_d;
    exp_h = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    cpu_if.req   = 1'b1;
    cpu_if.addr  = 8'd20;
    host_if.req  = 1'b1;
    host_if.addr = 8'd10;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle_inputs();
      @(negedge clk);
      if (i < 4) begin
        checks++;
        if (host_if.gnt !== exp_h[i] || cpu_if.gnt !== !exp_h[i]) begin
          failures++;
          $display("FAIL rr_gnt[%0d]: got host=%b cpu=%b expected host=%b cpu=%b",
                   i, host_if.gnt, cpu_if.gnt, exp_h[i], !exp_h[i]);
        end
      end
      if (i > 0) begin
        exp_d = exp_h[i-1] ? 32'h1111_0010 : 32'h2222_0020;
        checks++;
        if (host_if.rvalid !== exp_h[i-1] || cpu_if.rvalid !== !exp_h[i-1]) begin
          failures++;
          $display("FAIL rr_rvalid[%0d]: got host=%b cpu=%b expected host=%b cpu=%b",
                   i, host_if.rvalid, cpu_if.rvalid, exp_h[i-1], !exp_h[i-1]);
        end
        checks++;
        if (mem_rdata !== exp_d) begin
          failures++;
          $display("FAIL rr_rdata[%0d]: got %0h expected %0h", i, mem_rdata, exp_d);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    bit exp_h [10];
    exp_h = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    cpu_if.req   = 1'b1;
    cpu_if.addr  = 8'd20;
    host_if.req  = 1'b1;
    host_if.addr = 8'd10;
    host_lock    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (host_if.gnt !== exp_h[i] || cpu_if.gnt !== !exp_h[i]) begin
        failures++;
        $display("FAIL lock_gnt[%0d]: got host=%b cpu=%b expected host=%b cpu=%b",
                 i, host_if.gnt, cpu_if.gnt, exp_h[i], !exp_h[i]);
      end
      checks++;
      if (int'(dut.lock_cnt_q) > 4) begin
        failures++;
        $display("FAIL lock_cnt_bound[%0d]: got %0d expected <= 4", i, dut.lock_cnt_q);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  // HOST writes and CPU reads the same word on the first cycle out of reset.
  task automatic test_back_to_back();
    do_reset();
    host_if.req   = 1'b1;
    host_if.we    = 1'b1;
    host_if.addr  = 8'd3;
    host_if.wdata = 32'h7;
    cpu_if.req    = 1'b1;
    cpu_if.we     = 1'b0;
    cpu_if.addr   = 8'd3;
    @(negedge clk);
    checks++;
    if (host_if.gnt !== 1'b1 || cpu_if.gnt !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_gnt: got host=%b cpu=%b expected 1 0", host_if.gnt, cpu_if.gnt);
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd3 || mem_wdata !== 32'h7) begin
      failures++;
      $display("FAIL b2b_write_bus: got we=%b addr=%0h wdata=%0h expected 1 3 7",
               mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    host_if.req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_if.gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd3) begin
      failures++;
      $display("FAIL b2b_read_gnt: got gnt=%b we=%b addr=%0h expected 1 0 3",
               cpu_if.gnt, mem_we, mem_addr);
    end
    checks++;
    if (host_if.rvalid !== 1'b0 || cpu_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_write_no_resp: got host=%b cpu=%b expected 0 0",
               host_if.rvalid, cpu_if.rvalid);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== 32'h7) begin
      failures++;
      $display("FAIL b2b_read_data: got rvalid=%b rdata=%0h expected 1 7",
               cpu_if.rvalid, cpu_if.rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midread();
    do_reset();
    host_if.req  = 1'b1;
    host_if.addr = 8'd10;
    @(negedge clk);
    checks++;
    if (host_if.gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_gnt: got %b expected 1", host_if.gnt);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (host_if.gnt !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 8'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got gnt=%b en=%b addr=%0h expected 0 0 0",
               host_if.gnt, mem_en, mem_addr);
    end
    host_if.req = 1'b0;
    next_cycle();
    checks++;
    if (host_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_rvalid_low: got %b expected 0", host_if.rvalid);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (host_if.rvalid !== 1'b0 || cpu_if.rvalid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_rvalid_after[%0d]: got host=%b cpu=%b expected 0 0",
                 i, host_if.rvalid, cpu_if.rvalid);
      end
      next_cycle();
    end
  endtask

  // Ten idle cycles after a HOST grant must leave HOST as last owner.
  task automatic test_idle();
    do_reset();
    host_if.req  = 1'b1;
    host_if.addr = 8'd10;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || cpu_if.gnt !== 1'b0 || host_if.gnt !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet[%0d]: got en=%b cpu=%b host=%b expected 0 0 0",
                 i, mem_en, cpu_if.gnt, host_if.gnt);
      end
      checks++;
      if (host_if.rvalid !== (i == 0) || cpu_if.rvalid !== 1'b0) begin
        failures++;
        $display("FAIL idle_rvalid[%0d]: got host=%b cpu=%b expected host=%b cpu=0",
                 i, host_if.rvalid, cpu_if.rvalid, (i == 0));
      end
      next_cycle();
    end
    cpu_if.req  = 1'b1;
    host_if.req = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_if.gnt !== 1'b1 || host_if.gnt !== 1'b0) begin
      failures++;
      $display("FAIL idle_last_owner: got cpu=%b host=%b expected 1 0", cpu_if.gnt, host_if.gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | i;
    mem[3]  <= 32'hDEAD_0003;
    mem[5]  <= 32'h0000_002A;
    mem[10] <= 32'h1111_0010;
    mem[20] <= 32'h2222_0020;
    mem_rdata <= '0;
    #1;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_reset_midread();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
